neuron_mac_accumulator: RTL
===========================

# neuron_mac_accumulator

Per-neuron multiply-accumulate stage directly downstream of `weight_memory_control`. It consumes one input activation per `neuron_in_valid`, pairs it with the weight that the memory returns one cycle later, accumulates `num_weights` products plus a per-neuron bias, and emits one saturated fixed-point sum per frame. Its `output_valid` pulse drives the `output_valid` input of the paired `weight_memory_control`, which rewinds that block's read address.

## Interface
- `data_bits`, 16: width of activations, weights, bias and result; all signed two's complement.
- `frac_bits`, 8: fractional bits of the Q format shared by activations, weights, bias and result.
- `num_weights`, 784: products per frame.
- `layer_no`, 0: layer index matched against `config_layer_no` for bias load.
- `neuron_no`, 0: neuron index matched against `config_neuron_no` for bias load.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `neuron_in_valid` in 1: activation strobe; the same signal feeds `weight_memory_control`.
- `neuron_in` in `data_bits`: activation, sampled with `neuron_in_valid`.
- `weight_in` in `data_bits`: `weight_out` of the memory, valid the cycle after the strobe.
- `bias_valid` in 1: bias write strobe.
- `bias_value` in 32: zero-padded bias; bits `[data_bits-1:0]` are used.
- `config_layer_no` in 32: target layer of the bias write.
- `config_neuron_no` in 32: target neuron of the bias write.
- `output_valid` out 1: one-cycle result strobe; also rewinds the memory read address.
- `neuron_sum` out `data_bits`: saturated result; held until the next result.
- `overrun` out 1: sticky flag, set when an input is dropped.

## Operation
- Accumulator width is `acc_bits = 2*data_bits + $clog2(num_weights)`. It is signed and never wraps within a frame.
- Pipeline stages:
  - S0 registers `neuron_in` and the valid bit, aligning them with `weight_in`.
  - S1 registers the full-width signed product `x*w` (2*`data_bits`).
  - S2 adds the sign-extended product into the accumulator.
- Input counter: counts accepted strobes from 0 to `num_weights`.
  - A strobe is accepted only in state ACCUM with count < `num_weights`.
  - Any other strobe is dropped: nothing enters the pipeline and `overrun` is set.
- FSM states:
  - ACCUM: the S2 product counter reaching `num_weights` moves to BIAS.
  - BIAS: adds `bias << frac_bits`, sign-extended to `acc_bits`, then moves to OUT.
  - OUT: computes `acc >>> frac_bits` (arithmetic, floor). It saturates this to [-2^(data_bits-1), 2^(data_bits-1)-1], loads `neuron_sum`, pulses `output_valid`, clears the accumulator and both counters, then moves to WAIT.
  - WAIT: one cycle, then ACCUM. Strobes during WAIT are dropped, because the memory rewinds its address this cycle.
- Bias register:
  - Loaded when `bias_valid`, `config_layer_no==layer_no` and `config_neuron_no==neuron_no` all hold.
  - A load at or before the BIAS edge affects the current frame; a later load affects the next frame.
  - A non-matching write is ignored.
- `overrun` is cleared only by reset.
- Reset values: `output_valid`=0, `neuron_sum`=0, `overrun`=0, bias=0, accumulator=0, counters=0, state=ACCUM, pipeline valids=0.
- Reset mid-frame discards all partial state. The first strobe after reset release starts a new frame.

## Timing
- Let L be the edge that samples the last (`num_weights`-th) accepted strobe.
- Edge sequence for the last strobe:
  - L+1: S1 captures the product.
  - L+2: S2 accumulates it.
  - L+3: BIAS.
  - L+4: `neuron_sum` updates and `output_valid` rises for exactly one cycle.
- Latency from the last strobe to the result is 4 cycles, independent of gaps between strobes.
- Strobes sampled at edges L+1..L+5 are dropped and set `overrun`. The next frame's first strobe is legal at edge L+6.
- `neuron_in_valid` needs no contiguity; gaps are allowed anywhere.
- Throughput is one product per cycle.

## Test plan
- Frame sum:
  - Stimulus: `num_weights`=4, all weights 0x0100, inputs 0x0100, 0x0200, 0x0300, 0x0400 back-to-back, bias 0.
  - Response: `neuron_sum`=0x0A00, `output_valid` high exactly at L+4 for 1 cycle.
- Saturation:
  - Stimulus: 4 products of 0x7FFF·0x7FFF.
  - Response: `neuron_sum`=0x7FFF.
  - Stimulus: 4 products of 0x8000·0x7FFF.
  - Response: `neuron_sum`=0x8000.
- Bias match:
  - Stimulus: bias 0x0080 written with matching layer/neuron, then the first scenario.
  - Response: `neuron_sum`=0x0A80.
  - Stimulus: repeat with `config_neuron_no`=`neuron_no`+1.
  - Response: `neuron_sum` stays 0x0A80 (bias unchanged).
- Gapped strobes:
  - Stimulus: the first scenario with 3 idle cycles between each input.
  - Response: `neuron_sum`=0x0A00, still 4 cycles after the last strobe.
- Overrun:
  - Stimulus: a 5th strobe at L+1.
  - Response: dropped, `neuron_sum`=0x0A00, `overrun`=1.
  - Stimulus: next frame starting at L+6.
  - Response: correct result.
- Reset mid-frame:
  - Stimulus: assert `reset` low after 2 of 4 inputs, then release.
  - Response: all outputs and bias are 0. A full new frame gives 0x0A00 with no residue.

Source files
------------

// File: rtl/neuron_mac_accumulator.sv
// Per-neuron multiply-accumulate stage: pairs activations with memory weights,
// sums a frame of products plus bias, and emits one saturated fixed-point result.
module neuron_mac_accumulator #(
    parameter int data_bits   = 16,
    parameter int frac_bits   = 8,
    parameter int num_weights = 784,
    parameter int layer_no    = 0,
    parameter int neuron_no   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 neuron_in_valid,
    input  logic [data_bits-1:0] neuron_in,
    input  logic [data_bits-1:0] weight_in,
    input  logic                 bias_valid,
    input  logic [31:0]          bias_value,
    input  logic [31:0]          config_layer_no,
    input  logic [31:0]          config_neuron_no,
    output logic                 output_valid,
    output logic [data_bits-1:0] neuron_sum,
    output logic                 overrun
);

    localparam int prod_bits = 2 * data_bits;
    localparam int acc_bits  = prod_bits + $clog2(num_weights);
    localparam int cnt_bits  = $clog2(num_weights + 1);
    localparam int pad_bits  = acc_bits - data_bits - frac_bits;

    localparam logic [cnt_bits-1:0] cnt_max  = cnt_bits'(num_weights);
    localparam logic [cnt_bits-1:0] cnt_last = cnt_bits'(num_weights - 1);
    localparam logic [cnt_bits-1:0] cnt_one  = cnt_bits'(1);

    localparam logic [31:0] layer_id  = 32'(layer_no);
    localparam logic [31:0] neuron_id = 32'(neuron_no);

    localparam logic signed [acc_bits-1:0] sum_max =
        acc_bits'((longint'(1) <<< (data_bits - 1)) - 1);
    localparam logic signed [acc_bits-1:0] sum_min =
        acc_bits'(-(longint'(1) <<< (data_bits - 1)));

    typedef enum logic [1:0] {
        ACCUM,
        BIAS,
        OUT,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [cnt_bits-1:0] in_cnt;
    logic [cnt_bits-1:0] prod_cnt;

    logic                        s0_valid;
    logic signed [data_bits-1:0] s0_x;
    logic                        s1_valid;
    logic signed [prod_bits-1:0] s1_prod;

    logic signed [acc_bits-1:0] acc;
    logic signed [acc_bits-1:0] acc_shift;
    logic signed [acc_bits-1:0] prod_ext;
    logic signed [acc_bits-1:0] bias_ext;

    logic [data_bits-1:0] bias_q;
    logic [data_bits-1:0] bias_cur;
    logic [data_bits-1:0] sum_sat;

    logic accept;
    logic drop;
    logic bias_hit;
    logic prod_last;
    logic unused_bias_pad;

    assign accept = neuron_in_valid
                 && (state == ACCUM)
                 && (in_cnt < cnt_max);
    assign drop = neuron_in_valid && !accept;

    assign prod_last = (state == ACCUM)
                    && s1_valid
                    && (prod_cnt == cnt_last);

    assign bias_hit = bias_valid
                   && (config_layer_no == layer_id)
                   && (config_neuron_no == neuron_id);

    // A write landing on the BIAS edge itself still counts for this frame.
    assign bias_cur = bias_hit ? bias_value[data_bits-1:0] : bias_q;

    assign unused_bias_pad = ^bias_value[31:data_bits];

    assign prod_ext = {{(acc_bits - prod_bits){s1_prod[prod_bits-1]}},
                       s1_prod};

    assign bias_ext = {{pad_bits{bias_cur[data_bits-1]}},
                       bias_cur,
                       {frac_bits{1'b0}}};

    assign acc_shift = acc >>> frac_bits;

    always_comb begin
        sum_sat = acc_shift[data_bits-1:0];
        if (acc_shift > sum_max) begin
            sum_sat = sum_max[data_bits-1:0];
        end else if (acc_shift < sum_min) begin
            sum_sat = sum_min[data_bits-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ACCUM: begin
                if (prod_last) begin
                    state_next = BIAS;
                end
            end
            BIAS: state_next = OUT;
            OUT:  state_next = WAIT;
            WAIT: state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // S0 aligns the activation with the weight returned a cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid <= 1'b0;
            s0_x     <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_x <= neuron_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_prod <= prod_bits'(s0_x)
                         * prod_bits'($signed(weight_in));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt <= '0;
        end else if (state == OUT) begin
            in_cnt <= '0;
        end else if (accept) begin
            in_cnt <= in_cnt + cnt_one;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            prod_cnt <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (s1_valid) begin
                        acc      <= acc + prod_ext;
                        prod_cnt <= prod_cnt + cnt_one;
                    end
                end
                BIAS: acc <= acc + bias_ext;
                OUT: begin
                    acc      <= '0;
                    prod_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            output_valid <= 1'b0;
            neuron_sum   <= '0;
        end else begin
            output_valid <= (state == OUT);
            if (state == OUT) begin
                neuron_sum <= sum_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_q <= '0;
        end else if (bias_hit) begin
            bias_q <= bias_value[data_bits-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

endmodule
